// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline-side and SRAM-pin signals of the shared memory port
// slave: the arbiter; master: the pipeline stages plus the board SRAM.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              stall_req;

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ack, mem_rdata, mem_ack, stall_req,
        output sram_addr, sram_wdata, sram_ce_n, sram_oe_n, sram_we_n
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack, stall_req,
        input  sram_addr, sram_wdata, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one 16-bit SRAM port between fetch and data requesters
// Fixed-length SRAM access FSM, data side has priority, one-cycle ack per completion.
module mem_port_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              owner_mem_q;
    logic              we_q;
    logic              if_ack_q;
    logic              mem_ack_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_wdata_q;
    logic              sram_ce_n_q;
    logic              sram_oe_n_q;
    logic              sram_we_n_q;

    logic              mem_elig_d;
    logic              if_elig_d;
    logic              grant_we_d;
    logic [ADDR_W-1:0] grant_addr_d;

    // A requester whose ack is showing this cycle is dropping its request; never re-grant it.
    always_comb begin
        mem_elig_d   = bus.mem_req & ~mem_ack_q;
        if_elig_d    = bus.if_req & ~if_ack_q;
        grant_we_d   = mem_elig_d & bus.mem_we;
        grant_addr_d = mem_elig_d ? bus.mem_addr : bus.if_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_mem_q  <= 1'b0;
            we_q         <= 1'b0;
            if_ack_q     <= 1'b0;
            mem_ack_q    <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_ce_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            sram_we_n_q  <= 1'b1;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_elig_d || if_elig_d) begin
                        state_q     <= ACCESS;
                        cnt_q       <= '0;
                        owner_mem_q <= mem_elig_d;
                        we_q        <= grant_we_d;
                        sram_addr_q <= grant_addr_d;
                        if (mem_elig_d) begin
                            sram_wdata_q <= bus.mem_wdata;
                        end
                        sram_ce_n_q <= 1'b0;
                        // Writes spend counter 0 on address setup before we_n falls.
                        sram_oe_n_q <= grant_we_d;
                        sram_we_n_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= IDLE;
                        sram_ce_n_q <= 1'b1;
                        sram_oe_n_q <= 1'b1;
                        sram_we_n_q <= 1'b1;
                        if (owner_mem_q) begin
                            mem_ack_q <= 1'b1;
                            if (!we_q) begin
                                mem_rdata_q <= bus.sram_rdata;
                            end
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= bus.sram_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (we_q) begin
                            sram_we_n_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.stall_req  = (bus.if_req & ~if_ack_q) | (bus.mem_req & ~mem_ack_q);
    assign bus.if_ack     = if_ack_q;
    assign bus.mem_ack    = mem_ack_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;
    assign bus.sram_ce_n  = sram_ce_n_q;
    assign bus.sram_oe_n  = sram_oe_n_q;
    assign bus.sram_we_n  = sram_we_n_q;
endmodule
